// File: rtl/falu_trn_sched_pkg.sv
// Shared constants for the FP transfer scheduler: tag width, TRN sub-op codes
// and FCLASS result bit positions.
package falu_trn_sched_pkg;

    localparam int FALU_TRN_TAG_W = 6;

    localparam logic [2:0] FPU_SUBOP_TRN_INT2FP = 3'd0;
    localparam logic [2:0] FPU_SUBOP_TRN_FP2INT = 3'd1;
    localparam logic [2:0] FPU_SUBOP_TRN_FCLASS = 3'd2;

    localparam int FCLASS_NEG_INF  = 0;
    localparam int FCLASS_NEG_NORM = 1;
    localparam int FCLASS_NEG_SUB  = 2;
    localparam int FCLASS_NEG_ZERO = 3;
    localparam int FCLASS_POS_ZERO = 4;
    localparam int FCLASS_POS_SUB  = 5;
    localparam int FCLASS_POS_NORM = 6;
    localparam int FCLASS_POS_INF  = 7;
    localparam int FCLASS_SNAN     = 8;
    localparam int FCLASS_QNAN     = 9;

endpackage

// File: rtl/falu_trn_sched_trn.sv
// Combinational FP transfer/classify unit: INT2FP move with NaN-boxing,
// FP2INT move with sign-fill, and FCLASS one-hot classification.
module falu_trn_sched_trn
    import falu_trn_sched_pkg::*;
(
    input  logic [63:0] operand,
    input  logic        isdouble,
    input  logic [2:0]  op,
    output logic [63:0] result
);

    logic       sign;
    logic       exp_ones;
    logic       exp_zero;
    logic       man_zero;
    logic       quiet;
    logic [9:0] cls;

    always_comb begin
        sign     = isdouble ? operand[63]       : operand[31];
        exp_ones = isdouble ? &operand[62:52]   : &operand[30:23];
        exp_zero = isdouble ? ~|operand[62:52]  : ~|operand[30:23];
        man_zero = isdouble ? ~|operand[51:0]   : ~|operand[22:0];
        quiet    = isdouble ? operand[51]       : operand[22];

        cls = '0;
        if (exp_ones) begin
            if (man_zero)   cls[sign ? FCLASS_NEG_INF : FCLASS_POS_INF] = 1'b1;
            else if (quiet) cls[FCLASS_QNAN] = 1'b1;
            else            cls[FCLASS_SNAN] = 1'b1;
        end else if (exp_zero) begin
            if (man_zero)   cls[sign ? FCLASS_NEG_ZERO : FCLASS_POS_ZERO] = 1'b1;
            else            cls[sign ? FCLASS_NEG_SUB : FCLASS_POS_SUB] = 1'b1;
        end else begin
            cls[sign ? FCLASS_NEG_NORM : FCLASS_POS_NORM] = 1'b1;
        end
    end

    always_comb begin
        result = '0;
        case (op)
            FPU_SUBOP_TRN_INT2FP: result = isdouble ? operand : {32'hFFFF_FFFF, operand[31:0]};
            FPU_SUBOP_TRN_FP2INT: result = isdouble ? operand : {{32{operand[31]}}, operand[31:0]};
            FPU_SUBOP_TRN_FCLASS: result = {54'd0, cls};
            default:              result = '0;
        endcase
    end

endmodule

// File: rtl/falu_trn_sched.sv
// Round-robin scheduler sharing one transfer/classify unit between two FP lanes,
// with a small result queue. Optional perf counters: FALU_TRN_SCHED_PERF_EN.
module falu_trn_sched
    import falu_trn_sched_pkg::*;
#(
    parameter int TAG_W    = FALU_TRN_TAG_W,
    parameter int OQ_DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             FLUSH,
    input  logic             REQ0_VALID,
    output logic             REQ0_READY,
    input  logic [63:0]      REQ0_OPERAND,
    input  logic             REQ0_ISDOUBLE,
    input  logic [2:0]       REQ0_OP,
    input  logic [TAG_W-1:0] REQ0_TAG,
    input  logic             REQ1_VALID,
    output logic             REQ1_READY,
    input  logic [63:0]      REQ1_OPERAND,
    input  logic             REQ1_ISDOUBLE,
    input  logic [2:0]       REQ1_OP,
    input  logic [TAG_W-1:0] REQ1_TAG,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [63:0]      RES_DATA,
    output logic [TAG_W-1:0] RES_TAG,
    output logic             RES_LANE
`ifdef FALU_TRN_SCHED_PERF_EN
    ,
    output logic [31:0]      PERF_GRANTS,
    output logic [31:0]      PERF_CONFLICTS,
    output logic [31:0]      PERF_STALLS
`endif
);

    localparam int PTR_W = (OQ_DEPTH > 1) ? $clog2(OQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OQ_DEPTH);

    logic [63:0]      data_mem [OQ_DEPTH];
    logic [TAG_W-1:0] tag_mem  [OQ_DEPTH];
    logic             lane_mem [OQ_DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             rr_ptr_reg;
    logic [63:0]      hold_data_reg;
    logic [TAG_W-1:0] hold_tag_reg;
    logic             hold_lane_reg;

    logic             pop_ok;
    logic             space;
    logic             open;
    logic             grant0;
    logic             grant1;
    logic             push;
    logic             pop;
    logic [63:0]      trn_operand;
    logic             trn_isdouble;
    logic [2:0]       trn_op;
    logic [TAG_W-1:0] trn_tag;
    logic [63:0]      trn_result;

    assign RES_VALID = (count_reg != '0);
    assign pop_ok    = RES_VALID & RES_READY;
    assign space     = (count_reg < DEPTH_C) | pop_ok;
    assign open      = RST_N & ~FLUSH & space;

    // READY is an offer based on the other lane and the pointer, never on own VALID.
    assign REQ0_READY = open & (~REQ1_VALID | ~rr_ptr_reg);
    assign REQ1_READY = open & (~REQ0_VALID |  rr_ptr_reg);
    assign grant0     = REQ0_READY & REQ0_VALID;
    assign grant1     = REQ1_READY & REQ1_VALID;
    assign push       = grant0 | grant1;
    assign pop        = pop_ok & ~FLUSH;

    assign trn_operand  = grant1 ? REQ1_OPERAND  : REQ0_OPERAND;
    assign trn_isdouble = grant1 ? REQ1_ISDOUBLE : REQ0_ISDOUBLE;
    assign trn_op       = grant1 ? REQ1_OP       : REQ0_OP;
    assign trn_tag      = grant1 ? REQ1_TAG      : REQ0_TAG;

    falu_trn_sched_trn u_trn (
        .operand  (trn_operand),
        .isdouble (trn_isdouble),
        .op       (trn_op),
        .result   (trn_result)
    );

    assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            rr_ptr_reg <= 1'b0;
            for (int i = 0; i < OQ_DEPTH; i++) begin
                data_mem[i] <= '0;
                tag_mem[i]  <= '0;
                lane_mem[i] <= 1'b0;
            end
        end else if (FLUSH) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr_reg] <= trn_result;
                tag_mem[wr_ptr_reg]  <= trn_tag;
                lane_mem[wr_ptr_reg] <= grant1;
                wr_ptr_reg           <= wr_ptr_reg + PTR_W'(1);
                rr_ptr_reg           <= ~grant1;
            end
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    // Last presented head is kept so RES_* holds its value once the queue empties.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            hold_data_reg <= '0;
            hold_tag_reg  <= '0;
            hold_lane_reg <= 1'b0;
        end else if (RES_VALID) begin
            hold_data_reg <= data_mem[rd_ptr_reg];
            hold_tag_reg  <= tag_mem[rd_ptr_reg];
            hold_lane_reg <= lane_mem[rd_ptr_reg];
        end
    end

    assign RES_DATA = RES_VALID ? data_mem[rd_ptr_reg] : hold_data_reg;
    assign RES_TAG  = RES_VALID ? tag_mem[rd_ptr_reg]  : hold_tag_reg;
    assign RES_LANE = RES_VALID ? lane_mem[rd_ptr_reg] : hold_lane_reg;

`ifdef FALU_TRN_SCHED_PERF_EN
    logic [31:0] perf_grants_reg;
    logic [31:0] perf_conflicts_reg;
    logic [31:0] perf_stalls_reg;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            perf_grants_reg    <= '0;
            perf_conflicts_reg <= '0;
            perf_stalls_reg    <= '0;
        end else begin
            if (push && perf_grants_reg != '1)
                perf_grants_reg <= perf_grants_reg + 32'd1;
            if (REQ0_VALID && REQ1_VALID && push && perf_conflicts_reg != '1)
                perf_conflicts_reg <= perf_conflicts_reg + 32'd1;
            if ((REQ0_VALID || REQ1_VALID) && !push && perf_stalls_reg != '1)
                perf_stalls_reg <= perf_stalls_reg + 32'd1;
        end
    end

    assign PERF_GRANTS    = perf_grants_reg;
    assign PERF_CONFLICTS = perf_conflicts_reg;
    assign PERF_STALLS    = perf_stalls_reg;
`endif

endmodule

// File: tb/tb_falu_trn_sched.sv
// Self-checking bench for falu_trn_sched: table-driven single-lane vectors plus
// hand-written round-robin, back-pressure, flush and reset sequences.
module tb_falu_trn_sched;

    localparam int DEPTH = 2;
    localparam logic [2:0] OP_I2F = 3'd0;
    localparam logic [2:0] OP_F2I = 3'd1;
    localparam logic [2:0] OP_CLS = 3'd2;

    logic        clk = 1'b0;
    logic        rst_n, flush, res_ready;
    logic        v0, v1, r0, r1, dbl0, dbl1;
    logic [63:0] opd0, opd1, exp0, exp1;
    logic [2:0]  op0, op1;
    logic [5:0]  tag0, tag1;
    logic        res_valid, res_lane;
    logic [63:0] res_data;
    logic [5:0]  res_tag;
`ifdef FALU_TRN_SCHED_PERF_EN
    logic [31:0] perf_grants, perf_conflicts, perf_stalls;
`endif

    always #5 clk = ~clk;

    falu_trn_sched #(.TAG_W(6), .OQ_DEPTH(DEPTH)) dut (
        .CLK(clk), .RST_N(rst_n), .FLUSH(flush),
        .REQ0_VALID(v0), .REQ0_READY(r0), .REQ0_OPERAND(opd0),
        .REQ0_ISDOUBLE(dbl0), .REQ0_OP(op0), .REQ0_TAG(tag0),
        .REQ1_VALID(v1), .REQ1_READY(r1), .REQ1_OPERAND(opd1),
        .REQ1_ISDOUBLE(dbl1), .REQ1_OP(op1), .REQ1_TAG(tag1),
        .RES_VALID(res_valid), .RES_READY(res_ready), .RES_DATA(res_data),
        .RES_TAG(res_tag), .RES_LANE(res_lane)
`ifdef FALU_TRN_SCHED_PERF_EN
        , .PERF_GRANTS(perf_grants), .PERF_CONFLICTS(perf_conflicts),
        .PERF_STALLS(perf_stalls)
`endif
    );

    typedef struct packed {
        logic [63:0] data;
        logic [5:0]  tag;
        logic        lane;
    } sb_t;

    typedef struct {
        logic        lane;
        logic [2:0]  op;
        logic        dbl;
        logic [63:0] operand;
        logic [5:0]  tag;
        logic [63:0] expect_data;
    } vec_t;

    sb_t  sb[$];
    int   grant_log[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_grants = 0;
    logic mptr = 1'b0;
    logic acc0 = 1'b0, acc1 = 1'b0, popped = 1'b0;
    logic rst_edge = 1'b1;
    vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) rst_edge <= !rst_n;

    // Reference model of queue/arbiter; pushes expected results at accept, pops at drain.
    always @(negedge clk) begin
        logic ev, sp, er0, er1;
        sb_t  e;
        acc0 = 1'b0; acc1 = 1'b0; popped = 1'b0;
        if (!rst_n) begin
            chk("rst_ready0", 64'(r0), 64'd0);
            chk("rst_ready1", 64'(r1), 64'd0);
            if (rst_edge) begin
                chk("rst_valid", 64'(res_valid), 64'd0);
                chk("rst_data", res_data, 64'd0);
                chk("rst_tag", 64'(res_tag), 64'd0);
                chk("rst_lane", 64'(res_lane), 64'd0);
            end
            sb.delete();
            mptr = 1'b0;
            n_grants = 0;
        end else begin
            ev  = (sb.size() != 0);
            sp  = (sb.size() < DEPTH) || (ev && res_ready);
            er0 = !flush && sp && (!v1 || !mptr);
            er1 = !flush && sp && (!v0 || mptr);
            chk("res_valid", 64'(res_valid), 64'(ev));
            chk("req0_ready", 64'(r0), 64'(er0));
            chk("req1_ready", 64'(r1), 64'(er1));
            if (ev && res_valid) begin
                chk("res_data", res_data, sb[0].data);
                chk("res_tag", 64'(res_tag), 64'(sb[0].tag));
                chk("res_lane", 64'(res_lane), 64'(sb[0].lane));
            end
            acc0 = v0 && r0;
            acc1 = v1 && r1;
            if (flush) begin
                sb.delete();
            end else begin
                if (ev && res_ready) begin
                    e = sb.pop_front();
                    popped = 1'b1;
                    $display("txn lane=%0d tag=%0d data=%h", e.lane, e.tag, e.data);
                end
                if (acc0) begin
                    e.data = exp0; e.tag = tag0; e.lane = 1'b0;
                    sb.push_back(e); mptr = 1'b1; grant_log.push_back(0); n_grants++;
                end else if (acc1) begin
                    e.data = exp1; e.tag = tag1; e.lane = 1'b1;
                    sb.push_back(e); mptr = 1'b0; grant_log.push_back(1); n_grants++;
                end
            end
        end
    end

    task automatic issue(input logic lane, input logic [2:0] op, input logic dbl,
                         input logic [63:0] opd, input logic [5:0] tag, input logic [63:0] xp);
        logic done = 1'b0;
        if (!lane) begin op0 = op; dbl0 = dbl; opd0 = opd; tag0 = tag; exp0 = xp; v0 = 1'b1; end
        else       begin op1 = op; dbl1 = dbl; opd1 = opd; tag1 = tag; exp1 = xp; v1 = 1'b1; end
        for (int c = 0; c < 50 && !done; c++) begin
            @(posedge clk); #1;
            done = lane ? acc1 : acc0;
        end
        if (!lane) v0 = 1'b0; else v1 = 1'b0;
        chk("issue_accepted", 64'(done), 64'd1);
    endtask

    task automatic wait_empty();
        for (int c = 0; c < 30 && sb.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b0, OP_I2F, 1'b0, 64'h0000_0000_3F80_0000, 6'd5,  64'hFFFF_FFFF_3F80_0000};
        tbl[1]  = '{1'b1, OP_F2I, 1'b0, 64'h0000_0000_BF80_0000, 6'd7,  64'hFFFF_FFFF_BF80_0000};
        tbl[2]  = '{1'b0, OP_F2I, 1'b0, 64'h1234_5678_3F80_0000, 6'd9,  64'h0000_0000_3F80_0000};
        tbl[3]  = '{1'b1, OP_I2F, 1'b1, 64'h0123_4567_89AB_CDEF, 6'd10, 64'h0123_4567_89AB_CDEF};
        tbl[4]  = '{1'b0, OP_CLS, 1'b1, 64'h7FF0_0000_0000_0000, 6'd11, 64'h80};
        tbl[5]  = '{1'b1, OP_CLS, 1'b0, 64'h0000_0000_7F80_0001, 6'd12, 64'h100};
        tbl[6]  = '{1'b0, OP_CLS, 1'b0, 64'h0000_0000_FF80_0000, 6'd13, 64'h001};
        tbl[7]  = '{1'b1, OP_CLS, 1'b1, 64'h8000_0000_0000_0000, 6'd14, 64'h008};
        tbl[8]  = '{1'b0, OP_CLS, 1'b0, 64'h0000_0000_0000_0001, 6'd15, 64'h020};
        tbl[9]  = '{1'b1, OP_CLS, 1'b1, 64'h7FF8_0000_0000_0000, 6'd16, 64'h200};
        tbl[10] = '{1'b0, 3'b111, 1'b1, 64'h0000_0000_0000_DEAD, 6'd17, 64'h0};
        tbl[11] = '{1'b1, OP_CLS, 1'b0, 64'h0000_0000_BF80_0000, 6'd18, 64'h002};
        tbl[12] = '{1'b0, OP_CLS, 1'b0, 64'h0000_0000_0000_0000, 6'd19, 64'h010};
        tbl[13] = '{1'b1, OP_CLS, 1'b1, 64'h0010_0000_0000_0000, 6'd20, 64'h040};

        rst_n = 1'b0; flush = 1'b0; res_ready = 1'b1;
        v0 = 1'b0; v1 = 1'b0; op0 = '0; op1 = '0; dbl0 = 1'b0; dbl1 = 1'b0;
        opd0 = '0; opd1 = '0; tag0 = '0; tag1 = '0; exp0 = '0; exp1 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++)
            issue(tbl[i].lane, tbl[i].op, tbl[i].dbl, tbl[i].operand, tbl[i].tag, tbl[i].expect_data);
        wait_empty();

        // Both lanes valid for four cycles: grants alternate starting at lane 0
        op0 = OP_CLS; dbl0 = 1'b1; opd0 = 64'h7FF0_0000_0000_0000; exp0 = 64'h80;  tag0 = 6'd30;
        op1 = OP_CLS; dbl1 = 1'b0; opd1 = 64'h0000_0000_7F80_0001; exp1 = 64'h100; tag1 = 6'd40;
        grant_log.delete();
        v0 = 1'b1; v1 = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (acc0) tag0 = tag0 + 6'd1;
            if (acc1) tag1 = tag1 + 6'd1;
        end
        v0 = 1'b0; v1 = 1'b0;
        chk("rr_grant_count", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk("rr_grant_order", 64'(grant_log[i]), 64'(i % 2));
        wait_empty();

        // Back-pressure: two fill the queue, third waits until the first pop
        res_ready = 1'b0;
        issue(1'b0, OP_I2F, 1'b0, 64'h0000_0000_4000_0000, 6'd21, 64'hFFFF_FFFF_4000_0000);
        issue(1'b1, OP_F2I, 1'b0, 64'h0000_0000_8000_0000, 6'd22, 64'hFFFF_FFFF_8000_0000);
        op0 = OP_CLS; dbl0 = 1'b1; opd0 = 64'h0; tag0 = 6'd23; exp0 = 64'h010; v0 = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_blocked", 64'(acc0), 64'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_accept_on_pop", 64'(acc0), 64'd1);
        chk("bp_pop_same_cycle", 64'(popped), 64'd1);
        v0 = 1'b0;
        wait_empty();

        // Flush with two queued, a pending request and a same-cycle pop
        res_ready = 1'b0;
        issue(1'b1, OP_I2F, 1'b1, 64'h1111_2222_3333_4444, 6'd50, 64'h1111_2222_3333_4444);
        issue(1'b0, OP_F2I, 1'b1, 64'h5555_6666_7777_8888, 6'd51, 64'h5555_6666_7777_8888);
        op0 = OP_I2F; dbl0 = 1'b1; opd0 = 64'h9; tag0 = 6'd52; exp0 = 64'h9; v0 = 1'b1;
        flush = 1'b1; res_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_no_accept", 64'(acc0), 64'd0);
        chk("flush_emptied", 64'(res_valid), 64'd0);
        op1 = OP_I2F; dbl1 = 1'b1; opd1 = 64'hA; tag1 = 6'd53; exp1 = 64'hA; v1 = 1'b1;
        @(posedge clk); #1;
        chk("flush_ptr_held", 64'(acc1), 64'd1);
        v1 = 1'b0;
        @(posedge clk); #1;
        chk("post_flush_lane0", 64'(acc0), 64'd1);
        v0 = 1'b0;
        wait_empty();

        // Reset while the queue is full
        res_ready = 1'b0;
        issue(1'b0, OP_I2F, 1'b0, 64'h1, 6'd60, 64'hFFFF_FFFF_0000_0001);
        issue(1'b1, OP_I2F, 1'b0, 64'h2, 6'd61, 64'hFFFF_FFFF_0000_0002);
        v0 = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_valid", 64'(res_valid), 64'd0);
        chk("rst_mid_data", res_data, 64'd0);
`ifdef FALU_TRN_SCHED_PERF_EN
        chk("perf_grants_rst", 64'(perf_grants), 64'd0);
        chk("perf_conflicts_rst", 64'(perf_conflicts), 64'd0);
        chk("perf_stalls_rst", 64'(perf_stalls), 64'd0);
`endif
        @(posedge clk); #1;
        v0 = 1'b0; rst_n = 1'b1; res_ready = 1'b1;
        issue(tbl[0].lane, tbl[0].op, tbl[0].dbl, tbl[0].operand, tbl[0].tag, tbl[0].expect_data);
        wait_empty();
`ifdef FALU_TRN_SCHED_PERF_EN
        chk("perf_grants", 64'(perf_grants), 64'(n_grants));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/falu_trn_sched.md
Name: falu_trn_sched

Overview:
- Shares one FP transfer/classify datapath (INT2FP move with NaN-boxing, FP2INT move with sign-fill, FCLASS) between the two FP issue lanes of the superscalar core.
- Arbitrates between the lanes round-robin and drives the combinational datapath with the winner's operand.
- Captures results, with their destination tags, into a small output queue that drains to FP/INT writeback under valid/ready back-pressure.

Parameters:
- TAG_W, 6, width of destination/ROB tag carried with each request.
- OQ_DEPTH, 2, output queue entries; power of two, minimum 2.

Ports:
- CLK  in  1  core clock
- RST_N  in  1  synchronous reset, active low
- FLUSH  in  1  pipeline flush; discards queued results
- REQ0_VALID  in  1  lane 0 request valid
- REQ0_READY  out  1  lane 0 request accepted this cycle
- REQ0_OPERAND  in  64  lane 0 source value
- REQ0_ISDOUBLE  in  1  lane 0 double precision
- REQ0_OP  in  3  lane 0 TRN sub-op (FPU_SUBOP_TRN_*)
- REQ0_TAG  in  TAG_W  lane 0 destination tag
- REQ1_VALID / REQ1_READY / REQ1_OPERAND / REQ1_ISDOUBLE / REQ1_OP / REQ1_TAG  same as lane 0, for lane 1
- RES_VALID  out  1  result at queue head valid
- RES_READY  in  1  writeback accepts head
- RES_DATA  out  64  result value
- RES_TAG  out  TAG_W  result tag
- RES_LANE  out  1  originating lane

Behaviour:
- Reset (RST_N low at CLK edge) values: queue empty, RES_VALID=0, RES_DATA=0, RES_TAG=0, RES_LANE=0, round-robin pointer=lane 0, REQx_READY=0.
- space = (count < OQ_DEPTH) | (RES_VALID & RES_READY). Same-cycle pop frees a slot for push.
- Grant (combinational, one lane per cycle):
  - Only one lane valid: that lane wins if space.
  - Both lanes valid: the pointer's lane wins if space.
  - REQx_READY = grant to lane x. A lane's READY never depends on its own VALID.
- Pointer update: on any grant, pointer <= other lane (not the granted lane). It holds when there is no grant.
- Datapath:
  - The granted lane's operand, ISDOUBLE and OP feed the transfer unit.
  - The output is pushed with the tag and lane at the grant edge.
  - Latency: accept at edge N; result is visible on RES_* after edge N; pop is possible at edge N+1.
- Sub-op results:
  - INT2FP, single: upper 32 bits forced to 1.
  - FP2INT, single: upper 32 bits copy bit 31.
  - Double: passthrough.
  - FCLASS: 10-bit one-hot class mask, zero-extended.
  - Undefined OP: result 0, still pushed; no error raised.
- Queue:
  - Circular buffer; rd/wr pointers of log2(OQ_DEPTH) bits, wrapping naturally; count of log2(OQ_DEPTH)+1 bits.
  - RES_* is driven from the head entry.
  - RES_DATA/TAG hold stable while RES_VALID & ~RES_READY.
- Full: both READY=0 unless a pop occurs that cycle.
- Empty: RES_VALID=0; the RES_* data is don't-care but holds its last value.
- FLUSH:
  - Same edge: queue emptied, count=0.
  - Both READY forced 0 in the FLUSH cycle; no grant or pointer change.
  - A same-cycle pop is absorbed by the flush.
- Reset mid-operation: any queued results are lost; no RES_VALID in the cycle after reset.

Optional Feature:
- Macro: FALU_TRN_SCHED_PERF_EN.
- With the macro, add outputs PERF_GRANTS (32, total accepted requests), PERF_CONFLICTS (32, cycles with both lanes valid and exactly one granted) and PERF_STALLS (32, cycles with any lane valid and no grant).
  - Counters saturate at all-ones.
  - Counters clear on reset, not on FLUSH.
- Without the macro, these ports and the counters are absent; the remaining behaviour is identical.

Decomposition:
- core_typedefs.vh already holds the FPU_SUBOP_TRN_* codes and the FCLASS bit positions. Add FALU_TRN_TAG_W to it.
- One natural sub-module: the existing transfer/classify unit FALU_TRN, instantiated unmodified.
- Queue and arbiter are written inline.

Test Plan:
- Single-lane move: lane0 INT2FP, single, operand 0x0000_0000_3F80_0000, tag 5 → next cycle RES_DATA=0xFFFF_FFFF_3F80_0000, RES_TAG=5, RES_LANE=0.
- Round-robin fairness: both lanes valid for 4 cycles, RES_READY=1 → grants alternate 0,1,0,1. FCLASS of +inf DP 0x7FF0_0000_0000_0000 gives RES_DATA=0x80; sNaN SP 0x7F80_0001 gives 0x100.
- Back-pressure: RES_READY=0 with 3 requests → 2 accepted, then READY=0. Raise RES_READY → third accepted in the same cycle as the first pop; results come out in order with no duplication.
- Flush: 2 entries queued plus a request pending with FLUSH=1 → next cycle RES_VALID=0, request not accepted, pointer unchanged.
- FP2INT sign-fill: single, operand 0x0000_0000_BF80_0000 → 0xFFFF_FFFF_BF80_0000. Undefined OP 3'b111 → RES_DATA=0.
- Reset mid-stream: RST_N low while queue full → outputs return to reset values next edge. With FALU_TRN_SCHED_PERF_EN, the counters read 0.
